// File: rtl/ide_pkg.sv
// Shared ATA/IDE definitions: register selects, status bits, commands
// and the PIO transaction state encoding.
package ide_pkg;

  localparam logic [4:0] ATA_DATA    = 5'b10000;
  localparam logic [4:0] ATA_ERROR   = 5'b10001;
  localparam logic [4:0] ATA_FEATURE = 5'b10001;
  localparam logic [4:0] ATA_SECCNT  = 5'b10010;
  localparam logic [4:0] ATA_SECNUM  = 5'b10011;
  localparam logic [4:0] ATA_CYLLOW  = 5'b10100;
  localparam logic [4:0] ATA_CYLHIGH = 5'b10101;
  localparam logic [4:0] ATA_DRVHEAD = 5'b10110;
  localparam logic [4:0] ATA_STATUS  = 5'b10111;
  localparam logic [4:0] ATA_COMMAND = 5'b10111;
  localparam logic [4:0] ATA_ALTER   = 5'b01110;
  localparam logic [4:0] ATA_DEVCTRL = 5'b01110;

  localparam int STS_BSY  = 7;
  localparam int STS_DRDY = 6;
  localparam int STS_DF   = 5;
  localparam int STS_DSC  = 4;
  localparam int STS_DRQ  = 3;
  localparam int STS_CORR = 2;
  localparam int STS_IDX  = 1;
  localparam int STS_ERR  = 0;

  localparam logic [15:0] CMD_READ  = 16'h0020;
  localparam logic [15:0] CMD_WRITE = 16'h0030;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } xfer_state_t;

endpackage

// File: rtl/ide_phase_timer.sv
// Loadable down-counter with zero flag; times each PIO phase.
// Holds at zero until reloaded.
module ide_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ide_pio_xfer.sv
// ATA/IDE PIO transaction engine: register requests to timed IDE cycles.
// Build option IDE_IORDY_EN adds IORDY strobe stretching and ata_timeout.
module ide_pio_xfer
  import ide_pkg::*;
#(
  parameter int T_SETUP   = 3,
  parameter int T_PULSE   = 8,
  parameter int T_HOLD    = 2,
  parameter int T_RECOVER = 4,
`ifdef IDE_IORDY_EN
  parameter int T_IORDY_MAX = 255,
`endif
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ata_rd,
  input  logic        ata_wr,
  input  logic [4:0]  ata_addr,
  input  logic [15:0] ata_in,
  output logic [15:0] ata_out,
  output logic        ata_done,
`ifdef IDE_IORDY_EN
  input  logic        ide_iordy,
  output logic        ata_timeout,
`endif
  inout  wire  [15:0] ide_data_bus,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da
);

  xfer_state_t      state;
  logic             dir_rd;
  logic [15:0]      wdata;
  logic             drive;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;
  logic             stretch;

  ide_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  assign ide_data_bus = drive ? wdata : 16'hzzzz;

`ifdef IDE_IORDY_EN
  logic [15:0] ext;
  logic        tmo_cur;
  // Stay in the last strobe cycle while the device holds IORDY low.
  assign stretch = ~ide_iordy && (ext < 16'(T_IORDY_MAX));
`else
  assign stretch = 1'b0;
`endif

  always_comb begin
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      S_IDLE: if (ata_rd || ata_wr) begin
        load     = 1'b1;
        load_val = CNT_W'(T_SETUP - 1);
      end
      S_SETUP: if (zero) begin
        load     = 1'b1;
        load_val = CNT_W'(T_PULSE - 1);
      end
      S_STROBE: if (zero && !stretch) begin
        load     = 1'b1;
        load_val = CNT_W'(T_HOLD - 1);
      end
      S_HOLD: if (zero) begin
        load     = 1'b1;
        load_val = CNT_W'(T_RECOVER - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      dir_rd   <= 1'b0;
      wdata    <= '0;
      drive    <= 1'b0;
      ata_out  <= '0;
      ata_done <= 1'b0;
      ide_dior <= 1'b1;
      ide_diow <= 1'b1;
      ide_cs   <= 2'b11;
      ide_da   <= '0;
`ifdef IDE_IORDY_EN
      ext         <= '0;
      tmo_cur     <= 1'b0;
      ata_timeout <= 1'b0;
`endif
    end else begin
      ata_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
`ifdef IDE_IORDY_EN
          ext <= '0;
`endif
          if (ata_rd || ata_wr) begin
            dir_rd <= ata_rd;
            wdata  <= ata_in;
            drive  <= ~ata_rd;
            ide_cs <= ata_addr[4:3];
            ide_da <= ata_addr[2:0];
            state  <= S_SETUP;
          end
        end
        S_SETUP: if (zero) begin
          ide_dior <= ~dir_rd;
          ide_diow <= dir_rd;
          state    <= S_STROBE;
        end
        S_STROBE: if (zero) begin
          if (!stretch) begin
            ide_dior <= 1'b1;
            ide_diow <= 1'b1;
            if (dir_rd) ata_out <= ide_data_bus;
`ifdef IDE_IORDY_EN
            tmo_cur <= ~ide_iordy;
`endif
            state <= S_HOLD;
          end
`ifdef IDE_IORDY_EN
          else begin
            ext <= ext + 16'd1;
          end
`endif
        end
        S_HOLD: if (zero) begin
          ide_cs   <= 2'b11;
          drive    <= 1'b0;
          ata_done <= 1'b1;
`ifdef IDE_IORDY_EN
          ata_timeout <= tmo_cur;
`endif
          state <= S_RECOVER;
        end
        S_RECOVER: if (zero) begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ide_pio_xfer.sv
// Self-checking bench for ide_pio_xfer: timeline model of each
// IDE cycle compared period by period.
module tb_ide_pio_xfer;
  import ide_pkg::*;

  localparam int TS  = 3;
  localparam int TP  = 8;
  localparam int TH  = 2;
  localparam int TR  = 4;
  localparam int LEN = TS + TP + TH;
  localparam int PER = LEN + TR + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ata_rd = 1'b0;
  logic        ata_wr = 1'b0;
  logic [4:0]  ata_addr = '0;
  logic [15:0] ata_in = '0;
  wire  [15:0] ata_out;
  wire         ata_done;
  wire  [15:0] ide_data_bus;
  wire         ide_dior;
  wire         ide_diow;
  wire  [1:0]  ide_cs;
  wire  [2:0]  ide_da;
  logic [15:0] dev_data = '0;
`ifdef IDE_IORDY_EN
  logic        ide_iordy = 1'b1;
  wire         ata_timeout;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_out = '0;

  // Device side: answers reads while DIOR- is low.
  assign ide_data_bus = (ide_dior == 1'b0) ? dev_data : 16'hzzzz;

  ide_pio_xfer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ata_rd       (ata_rd),
    .ata_wr       (ata_wr),
    .ata_addr     (ata_addr),
    .ata_in       (ata_in),
    .ata_out      (ata_out),
    .ata_done     (ata_done),
`ifdef IDE_IORDY_EN
    .ide_iordy    (ide_iordy),
    .ata_timeout  (ata_timeout),
`endif
    .ide_data_bus (ide_data_bus),
    .ide_dior     (ide_dior),
    .ide_diow     (ide_diow),
    .ide_cs       (ide_cs),
    .ide_da       (ide_da)
  );

  always #5 clk = ~clk;

  // One full transaction; request is latched at the next posedge.
  task automatic do_xfer(input bit rd, input bit wr,
                         input logic [4:0] addr,
                         input logic [15:0] data,
                         input logic [15:0] dev,
                         input string tag);
    bit is_rd;
    logic [7:0] exp_v;
    logic [7:0] got_v;
    is_rd = rd;
    @(negedge clk);
    ata_rd = rd;
    ata_wr = wr;
    ata_addr = addr;
    ata_in = data;
    dev_data = dev;
    for (int off = 0; off < LEN + TR; off++) begin
      @(negedge clk);
      ata_addr = 5'($urandom);
      ata_in = 16'($urandom);
      if (is_rd && off == TS + TP) exp_out = dev;
      exp_v = {!(is_rd && off >= TS && off < TS + TP),
               !(!is_rd && off >= TS && off < TS + TP),
               (off < LEN) ? addr[4:3] : 2'b11,
               addr[2:0],
               off == LEN};
      got_v = {ide_dior, ide_diow, ide_cs, ide_da, ata_done};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL %s off=%0d dior/diow/cs/da/done got %b exp %b",
                 tag, off, got_v, exp_v);
      end
      tests++;
      if (ata_out !== exp_out) begin
        fails++;
        $display("FAIL %s off=%0d ata_out got %h exp %h",
                 tag, off, ata_out, exp_out);
      end
      if (!is_rd && off < LEN) begin
        tests++;
        if (ide_data_bus !== data) begin
          fails++;
          $display("FAIL %s off=%0d bus got %h exp %h",
                   tag, off, ide_data_bus, data);
        end
      end
      if (off == LEN) begin
        ata_rd = 1'b0;
        ata_wr = 1'b0;
      end
    end
    @(negedge clk);
    tests++;
    if ({ata_done, ide_dior, ide_diow} !== 3'b011) begin
      fails++;
      $display("FAIL %s idle done/dior/diow got %b exp 011",
               tag, {ata_done, ide_dior, ide_diow});
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({ide_dior, ide_diow, ide_cs, ide_da, ata_done, ata_out} !==
        {1'b1, 1'b1, 2'b11, 3'b000, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL reset got dior=%b diow=%b cs=%b da=%b done=%b out=%h",
               ide_dior, ide_diow, ide_cs, ide_da, ata_done, ata_out);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_status_read;
    do_xfer(1'b1, 1'b0, ATA_STATUS, 16'h1234, 16'h0058, "status_rd");
  endtask

  task automatic test_write;
    do_xfer(1'b0, 1'b1, ATA_SECCNT, 16'h0002, 16'hdead, "seccnt_wr");
  endtask

  task automatic test_rd_wr_both;
    do_xfer(1'b1, 1'b1, ATA_CYLLOW, 16'hbeef, 16'h00a5, "rd_wr_both");
  endtask

  task automatic test_poll;
    int dones;
    int last_end;
    int min_gap;
    bit prev_dior;
    dones = 0;
    last_end = -1;
    min_gap = 1000;
    prev_dior = 1'b1;
    @(negedge clk);
    ata_rd = 1'b1;
    ata_wr = 1'b0;
    ata_addr = ATA_STATUS;
    dev_data = 16'h0058;
    for (int t = 0; t < 3 * PER + 4; t++) begin
      int off;
      int n;
      logic [1:0] exp_v;
      @(negedge clk);
      off = t % PER;
      n = t / PER;
      exp_v = {!(n < 3 && off >= TS && off < TS + TP),
               n < 3 && off == LEN};
      tests++;
      if ({ide_dior, ata_done} !== exp_v) begin
        fails++;
        $display("FAIL poll t=%0d dior/done got %b exp %b",
                 t, {ide_dior, ata_done}, exp_v);
      end
      if (ide_dior && !prev_dior) last_end = t;
      if (!ide_dior && prev_dior && last_end >= 0 &&
          t - last_end < min_gap) min_gap = t - last_end;
      prev_dior = ide_dior;
      if (ata_done) dones++;
      if (n == 2 && off == LEN) ata_rd = 1'b0;
    end
    exp_out = 16'h0058;
    tests++;
    if (dones != 3) begin
      fails++;
      $display("FAIL poll_dones got %0d exp 3", dones);
    end
    tests++;
    if (min_gap < TH + TR + 1 + TS) begin
      fails++;
      $display("FAIL poll_gap got %0d exp >= %0d", min_gap, TH + TR + 1 + TS);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ata_rd = 1'b1;
    ata_addr = ATA_STATUS;
    dev_data = 16'h7777;
    for (int i = 0; i < 20 && ide_dior; i++) @(negedge clk);
    tests++;
    if (ide_dior !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_wait dior got %b exp 0", ide_dior);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    exp_out = 16'h0000;
    tests++;
    if ({ide_dior, ide_diow, ide_cs, ata_done, ata_out} !==
        {1'b1, 1'b1, 2'b11, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL reset_mid got dior=%b diow=%b cs=%b done=%b out=%h",
               ide_dior, ide_diow, ide_cs, ata_done, ata_out);
    end
    ata_rd = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tests++;
      if ({ata_done, ide_dior} !== 2'b01) begin
        fails++;
        $display("FAIL reset_mid_quiet i=%0d done/dior got %b exp 01",
                 i, {ata_done, ide_dior});
      end
    end
    do_xfer(1'b1, 1'b0, ATA_STATUS, 16'h0, 16'h0050, "after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_xfer(kind != 1, kind != 0, 5'($urandom), 16'($urandom),
              16'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_status_read();
    test_write();
    test_rd_wr_both();
    test_poll();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
